// File: rtl/id_ex_if.sv
// ID -> ID/EX bundle and the registered EX-side outputs that feed the ALU.
// master: decode stage / bench side; slave: the id_ex_stage pipeline register.
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_uses_rt;
  logic              id_alu_src;
  logic [5:0]        id_operation;
  logic [1:0]        id_alu_op;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;

  logic              ex_valid;
  logic [DATA_W-1:0] ex_data1;
  logic [DATA_W-1:0] ex_data2;
  logic [DATA_W-1:0] ex_store_data;
  logic [5:0]        ex_operation;
  logic [1:0]        ex_alu_op;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_uses_rt, id_alu_src, id_operation, id_alu_op,
           id_reg_write, id_mem_read, id_mem_write,
    input  ex_valid, ex_data1, ex_data2, ex_store_data, ex_operation,
           ex_alu_op, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_uses_rt, id_alu_src, id_operation, id_alu_op,
           id_reg_write, id_mem_read, id_mem_write,
    output ex_valid, ex_data1, ex_data2, ex_store_data, ex_operation,
           ex_alu_op, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: load-use bubble insertion, EX/MEM and MEM/WB
// operand forwarding, stall/flush, and a saturating hazard-bubble counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  id_ex_if.slave            bus,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  input  logic              stall,
  input  logic              flush,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_count
);

  logic              r_valid;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic              r_alu_src;
  logic [5:0]        r_operation;
  logic [1:0]        r_alu_op;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  assign hazard_stall = bus.id_valid & r_valid & r_mem_read & (r_rd != '0) &
                        ((bus.id_rs == r_rd) | (bus.id_uses_rt & (bus.id_rt == r_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_alu_src    <= 1'b0;
      r_operation  <= '0;
      r_alu_op     <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      bubble_count <= '0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (stall) begin
      r_valid <= r_valid;
    end else if (hazard_stall) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      if (bubble_count != {CNT_W{1'b1}})
        bubble_count <= bubble_count + 1'b1;
    end else begin
      r_valid     <= bus.id_valid;
      r_rs        <= bus.id_rs;
      r_rt        <= bus.id_rt;
      r_rd        <= bus.id_rd;
      r_rs_data   <= bus.id_rs_data;
      r_rt_data   <= bus.id_rt_data;
      r_imm       <= bus.id_imm;
      r_alu_src   <= bus.id_alu_src;
      r_operation <= bus.id_operation;
      r_alu_op    <= bus.id_alu_op;
      r_reg_write <= bus.id_valid & bus.id_reg_write;
      r_mem_read  <= bus.id_valid & bus.id_mem_read;
      r_mem_write <= bus.id_valid & bus.id_mem_write;
    end
  end

  // MEM/WB first, then EX/MEM overrides so the younger result wins.
  always_comb begin
    fwd_a = r_rs_data;
    if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rs))
      fwd_a = memwb_result;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rs))
      fwd_a = exmem_result;

    fwd_b = r_rt_data;
    if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rt))
      fwd_b = memwb_result;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rt))
      fwd_b = exmem_result;
  end

  assign bus.ex_valid      = r_valid;
  assign bus.ex_data1      = fwd_a;
  assign bus.ex_data2      = r_alu_src ? r_imm : fwd_b;
  assign bus.ex_store_data = fwd_b;
  assign bus.ex_operation  = r_operation;
  assign bus.ex_alu_op     = r_alu_op;
  assign bus.ex_rd         = r_rd;
  assign bus.ex_reg_write  = r_reg_write & r_valid;
  assign bus.ex_mem_read   = r_mem_read & r_valid;
  assign bus.ex_mem_write  = r_mem_write & r_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized + directed bench for id_ex_stage with a queue-based scoreboard;
// a second instance with CNT_W=2 exercises bubble-counter saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        stall, flush;
  logic        hz0, hz1;
  logic [15:0] bc0;
  logic [1:0]  bc1;

  id_ex_if #(.DATA_W(32), .REG_AW(5)) bus0 ();
  id_ex_if #(.DATA_W(32), .REG_AW(5)) bus1 ();

  assign {bus1.id_valid, bus1.id_rs_data, bus1.id_rt_data, bus1.id_imm, bus1.id_rs,
          bus1.id_rt, bus1.id_rd, bus1.id_uses_rt, bus1.id_alu_src, bus1.id_operation,
          bus1.id_alu_op, bus1.id_reg_write, bus1.id_mem_read, bus1.id_mem_write} =
         {bus0.id_valid, bus0.id_rs_data, bus0.id_rt_data, bus0.id_imm, bus0.id_rs,
          bus0.id_rt, bus0.id_rd, bus0.id_uses_rt, bus0.id_alu_src, bus0.id_operation,
          bus0.id_alu_op, bus0.id_reg_write, bus0.id_mem_read, bus0.id_mem_write};

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall), .flush(flush), .hazard_stall(hz0), .bubble_count(bc0)
  );

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall), .flush(flush), .hazard_stall(hz1), .bubble_count(bc1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v;
    bit [4:0]  rs, rt, rd;
    bit [31:0] rsd, rtd, imm;
    bit        src;
    bit [5:0]  op;
    bit [1:0]  aop;
    bit        rw, mr, mw;
  } instr_t;

  typedef struct {
    bit        full;
    bit        hz;
    bit        v;
    bit [31:0] d1, d2, sd;
    bit [5:0]  op;
    bit [1:0]  aop;
    bit [4:0]  rd;
    bit        rw, mr, mw;
    int        bc, bc2;
  } exp_t;

  exp_t   q[$];
  instr_t ex;
  int     bc, bc2;
  int     checks = 0;
  int     failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the stage presents its outputs every cycle; sample mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("hazard_stall", {31'd0, hz0}, {31'd0, e.hz});
      chk("hazard_stall_sat", {31'd0, hz1}, {31'd0, e.hz});
      chk("ex_valid", {31'd0, bus0.ex_valid}, {31'd0, e.v});
      chk("ex_reg_write", {31'd0, bus0.ex_reg_write}, {31'd0, e.rw});
      chk("ex_mem_read", {31'd0, bus0.ex_mem_read}, {31'd0, e.mr});
      chk("ex_mem_write", {31'd0, bus0.ex_mem_write}, {31'd0, e.mw});
      chk("bubble_count", {16'd0, bc0}, e.bc);
      chk("bubble_count_sat", {30'd0, bc1}, e.bc2);
      if (e.v || e.full) begin
        chk("ex_data1", bus0.ex_data1, e.d1);
        chk("ex_data2", bus0.ex_data2, e.d2);
        chk("ex_store_data", bus0.ex_store_data, e.sd);
        chk("ex_operation", {26'd0, bus0.ex_operation}, {26'd0, e.op});
        chk("ex_alu_op", {30'd0, bus0.ex_alu_op}, {30'd0, e.aop});
        chk("ex_rd", {27'd0, bus0.ex_rd}, {27'd0, e.rd});
        chk("sat_ex_data1", bus1.ex_data1, e.d1);
      end
    end
  end

  // Source value seen by the ALU: newest writer of that register, r0 never forwarded.
  function automatic bit [31:0] fwd(input bit [4:0] r, input bit [31:0] cap);
    if (r != 0 && exmem_reg_write && exmem_rd == r) return exmem_result;
    if (r != 0 && memwb_reg_write && memwb_rd == r) return memwb_result;
    return cap;
  endfunction

  task automatic step();
    instr_t id;
    exp_t   e;
    bit     hz;
    id.v   = bus0.id_valid;
    id.rs  = bus0.id_rs;   id.rt  = bus0.id_rt;   id.rd  = bus0.id_rd;
    id.rsd = bus0.id_rs_data; id.rtd = bus0.id_rt_data; id.imm = bus0.id_imm;
    id.src = bus0.id_alu_src; id.op = bus0.id_operation; id.aop = bus0.id_alu_op;
    id.rw  = bus0.id_valid && bus0.id_reg_write;
    id.mr  = bus0.id_valid && bus0.id_mem_read;
    id.mw  = bus0.id_valid && bus0.id_mem_write;

    hz = id.v && ex.v && ex.mr && ex.rd != 0 &&
         (id.rs == ex.rd || (bus0.id_uses_rt && id.rt == ex.rd));

    e.full = 0; e.hz = hz; e.v = ex.v;
    e.d1 = fwd(ex.rs, ex.rsd);
    e.sd = fwd(ex.rt, ex.rtd);
    e.d2 = ex.src ? ex.imm : e.sd;
    e.op = ex.op; e.aop = ex.aop; e.rd = ex.rd;
    e.rw = ex.v && ex.rw; e.mr = ex.v && ex.mr; e.mw = ex.v && ex.mw;
    e.bc = bc; e.bc2 = bc2;
    q.push_back(e);

    if (flush || (!stall && hz)) begin
      ex.v = 0; ex.rw = 0; ex.mr = 0; ex.mw = 0;
      if (!flush) begin
        if (bc < 65535) bc++;
        if (bc2 < 3) bc2++;
      end
    end else if (!stall) begin
      ex = id;
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    rst_n = 1'b0;
    ex = '{default: 0};
    bc = 0; bc2 = 0;
    e = '{default: 0};
    e.full = 1;
    q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_id(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                        input bit [31:0] rsd, input bit [31:0] rtd, input bit [31:0] imm,
                        input bit src, input bit ut, input bit [5:0] op, input bit [1:0] aop,
                        input bit rw, input bit mr, input bit mw);
    bus0.id_valid = v; bus0.id_rs = rs; bus0.id_rt = rt; bus0.id_rd = rd;
    bus0.id_rs_data = rsd; bus0.id_rt_data = rtd; bus0.id_imm = imm;
    bus0.id_alu_src = src; bus0.id_uses_rt = ut; bus0.id_operation = op;
    bus0.id_alu_op = aop; bus0.id_reg_write = rw; bus0.id_mem_read = mr;
    bus0.id_mem_write = mw;
  endtask

  task automatic set_fwd(input bit ew, input bit [4:0] erd, input bit [31:0] er,
                         input bit mw, input bit [4:0] mrd, input bit [31:0] mr);
    exmem_reg_write = ew; exmem_rd = erd; exmem_result = er;
    memwb_reg_write = mw; memwb_rd = mrd; memwb_result = mr;
  endtask

  task automatic rand_inputs();
    set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
           $urandom_range(0, 3) == 0, 1'($urandom), 6'($urandom), 2'($urandom),
           1'($urandom), $urandom_range(0, 2) == 0, 1'($urandom));
    set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
            1'($urandom), 5'($urandom_range(0, 3)), $urandom);
    stall = $urandom_range(0, 7) == 0;
    flush = $urandom_range(0, 9) == 0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    do_reset();

    // plain capture
    set_id(1, 1, 2, 6, 5, 7, 0, 0, 1, 6'b000001, 2'b00, 1, 0, 0);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // forwarding priority, EX held by stall while forward sources change
    set_id(1, 3, 0, 7, 32'h11, 32'h22, 0, 0, 1, 6'd2, 2'b00, 1, 0, 0);
    step();
    stall = 1;
    set_fwd(1, 3, 32'hAA, 1, 3, 32'hBB);
    step();
    set_fwd(0, 3, 32'hAA, 1, 3, 32'hBB);
    step();
    stall = 0;
    set_id(1, 0, 0, 7, 32'h33, 32'h0, 0, 0, 1, 6'd2, 2'b00, 1, 0, 0);
    step();
    set_fwd(1, 0, 32'hAA, 1, 0, 32'hBB);
    step();
    set_fwd(0, 0, 0, 0, 0, 0);

    // load-use: ld r4, then add using r4
    set_id(1, 1, 0, 4, 32'h40, 0, 32'h8, 1, 0, 6'd3, 2'b11, 1, 1, 0);
    step();
    set_id(1, 4, 2, 5, 32'h9, 32'h1, 0, 0, 1, 6'd1, 2'b00, 1, 0, 0);
    step();
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // stall hold for 3 cycles, then flush overriding stall
    set_id(1, 2, 3, 9, 32'h1234, 32'h5678, 0, 0, 1, 6'd5, 2'b10, 1, 0, 1);
    step();
    stall = 1;
    repeat (3) step();
    flush = 1;
    step();
    stall = 0; flush = 0;
    step();

    // back-to-back dependent loads: five hazard bubbles, 2-bit counter saturates
    set_id(1, 4, 0, 4, 32'h4, 0, 32'h4, 1, 0, 6'd3, 2'b11, 1, 1, 0);
    repeat (11) step();

    // immediate selects data2 while store data follows forwarded rt
    set_id(1, 1, 2, 8, 32'h10, 32'h20, 32'hFFFFFFF0, 1, 0, 6'd4, 2'b11, 0, 0, 1);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stall = 1;
    set_fwd(1, 2, 32'hCAFE, 0, 0, 0);
    step();
    set_fwd(0, 2, 32'hCAFE, 1, 2, 32'hBEEF);
    step();
    stall = 0;
    set_fwd(0, 0, 0, 0, 0, 0);

    // randomized traffic with one mid-run reset
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        do_reset();
      end else begin
        rand_inputs();
        step();
      end
    end

    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU; captures decoded operands and control from ID and drives the ALU's data1, data2, operation and ALUOp inputs.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles.
- Supports external stall and flush, and keeps a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs_data, id_rt_data  in  DATA_W  register file read values
- id_imm  in  DATA_W  immediate, already sign-extended
- id_rs, id_rt, id_rd  in  REG_AW  source/destination register numbers
- id_uses_rt  in  1  instruction reads rt as an operand
- id_alu_src  in  1  1: data2 = immediate
- id_operation  in  6  ALU operation code
- id_alu_op  in  2  ALU mode: 00 normal, 01 ldi, 10 BNE, 11 ld/st address
- id_reg_write, id_mem_read, id_mem_write  in  1  control flags
- exmem_reg_write  in  1  EX/MEM stage writes a register
- exmem_rd  in  REG_AW  EX/MEM destination register
- exmem_result  in  DATA_W  EX/MEM result value
- memwb_reg_write  in  1  MEM/WB stage writes a register
- memwb_rd  in  REG_AW  MEM/WB destination register
- memwb_result  in  DATA_W  MEM/WB result value
- stall  in  1  downstream hold
- flush  in  1  branch taken; squash the captured instruction
- hazard_stall  out  1  load-use detected; PC and IF/ID must hold
- ex_valid  out  1  stage holds a real instruction
- ex_data1, ex_data2  out  DATA_W  ALU operands, after forwarding
- ex_store_data  out  DATA_W  forwarded rt value for stores
- ex_operation  out  6  registered operation code
- ex_alu_op  out  2  registered ALU mode
- ex_rd  out  REG_AW  registered destination register
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control; all forced 0 when ex_valid=0
- bubble_count  out  CNT_W  number of inserted bubbles, saturating

Behaviour:
Reset:
- rst_n low asynchronously clears every register: ex_valid, control flags, operation, alu_op, rd, captured data, bubble_count.
- All outputs read 0 while reset is held.

Load-use detection (combinational, from ID inputs and registered EX state):
- hazard_stall = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).

Register update, per rising edge, highest priority first:
1. flush=1: load a bubble (ex_valid=0, reg_write/mem_read/mem_write=0). Flush overrides stall and hazard.
2. stall=1: hold all registers unchanged.
3. hazard_stall=1: load a bubble; bubble_count increments.
4. Otherwise: capture all id_* fields and set ex_valid=id_valid. If id_valid=0, control flags are loaded as 0.

Bubble counter:
- Increments only on a hazard bubble (case 3 above).
- Saturates at 2^CNT_W-1; never wraps.
- Flush bubbles are not counted.

Forwarding (combinational on registered rs/rt):
- fwd_a = exmem_result if exmem_reg_write & exmem_rd!=0 & exmem_rd==rs.
- Else fwd_a = memwb_result if memwb_reg_write & memwb_rd!=0 & memwb_rd==rs.
- Else fwd_a = captured rs_data.
- EX/MEM always has priority over MEM/WB.
- fwd_b is computed identically using rt.

Outputs:
- ex_data1 = fwd_a.
- ex_data2 = captured imm if alu_src, else fwd_b.
- ex_store_data = fwd_b always.
- ALU latency through this stage: one cycle from ID capture to ALU operands valid.
- Register 0 is never forwarded; the captured value is used, which the register file returns as 0.
- No arithmetic is performed here; widths pass straight through.

Test Plan:
- Reset mid-run: drive instructions, assert rst_n=0 between edges -> all outputs 0 immediately; bubble_count=0.
- Plain capture: id_rs_data=5, id_rt_data=7, op=000001, alu_op=00, alu_src=0, no forwarding -> next cycle ex_data1=5, ex_data2=7, ex_valid=1.
- Forward priority: rs=3, exmem_rd=3 (result 0xAA), memwb_rd=3 (result 0xBB), both writing -> ex_data1=0xAA. Drop exmem_reg_write -> 0xBB. Set rs=0 -> captured value used.
- Load-use: EX holds ld with rd=4; ID add uses rs=4 -> hazard_stall=1; next cycle ex_valid=0 and bubble_count=1; following cycle the add is captured.
- Flush+stall together: stall=1, flush=1 -> bubble loaded (ex_valid=0, ex_reg_write=0); stall alone -> outputs hold for 3 cycles unchanged.
- Saturation and immediate: CNT_W=2, force 5 hazards -> bubble_count=3. alu_src=1, imm=0xFFFFFFF0 -> ex_data2=0xFFFFFFF0 while ex_store_data tracks forwarded rt.
